// File: rtl/udt_cfg_master.sv
// udt_cfg_master: single-outstanding AXI-Lite master for UDT config registers.
// Define UDT_CFG_TIMEOUT_EN to enable the bus-hang watchdog.
module udt_cfg_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ctrl_m_axi_aclk,
  input  logic        ctrl_m_axi_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        bus_err,
  output logic [31:0] ctrl_m_axi_awaddr,
  output logic        ctrl_m_axi_awvalid,
  input  logic        ctrl_m_axi_awready,
  output logic [31:0] ctrl_m_axi_wdata,
  output logic [3:0]  ctrl_m_axi_wstrb,
  output logic        ctrl_m_axi_wvalid,
  input  logic        ctrl_m_axi_wready,
  input  logic [1:0]  ctrl_m_axi_bresp,
  input  logic        ctrl_m_axi_bvalid,
  output logic        ctrl_m_axi_bready,
  output logic [31:0] ctrl_m_axi_araddr,
  output logic        ctrl_m_axi_arvalid,
  input  logic        ctrl_m_axi_arready,
  input  logic [31:0] ctrl_m_axi_rdata,
  input  logic [1:0]  ctrl_m_axi_rresp,
  input  logic        ctrl_m_axi_rvalid,
  output logic        ctrl_m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, ERR
  } state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done, w_done;
  logic        cmd_hs, abort;

  wire clk   = ctrl_m_axi_aclk;
  wire rst_n = ctrl_m_axi_aresetn;

  assign cmd_hs            = (state == IDLE) && cmd_valid;
  assign ctrl_m_axi_awaddr = addr_q;
  assign ctrl_m_axi_araddr = addr_q;
  assign ctrl_m_axi_wdata  = wdata_q;
  assign ctrl_m_axi_wstrb  = wstrb_q;

`ifdef UDT_CFG_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;
  logic        busy, done_now, tmo_q, err_q;

  assign busy     = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);
  assign done_now = ((state == WR_RESP) && ctrl_m_axi_bvalid) ||
                    ((state == RD_RESP) && ctrl_m_axi_rvalid);
  assign abort    = busy && (cnt == TO_LAST) && !done_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (cmd_hs)
        cnt <= '0;
      else if (busy)
        cnt <= cnt + 16'd1;
      if (abort) begin
        tmo_q <= 1'b1;
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_timeout = tmo_q;
  assign bus_err     = err_q;
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx           = state;
    cmd_ready          = 1'b0;
    rsp_valid          = 1'b0;
    ctrl_m_axi_awvalid = 1'b0;
    ctrl_m_axi_wvalid  = 1'b0;
    ctrl_m_axi_bready  = 1'b0;
    ctrl_m_axi_arvalid = 1'b0;
    ctrl_m_axi_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_nx = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        ctrl_m_axi_awvalid = !aw_done;
        ctrl_m_axi_wvalid  = !w_done;
        if ((aw_done || ctrl_m_axi_awready) &&
            (w_done || ctrl_m_axi_wready))
          state_nx = WR_RESP;
      end
      WR_RESP: begin
        ctrl_m_axi_bready = 1'b1;
        if (ctrl_m_axi_bvalid) state_nx = RSP;
      end
      RD_REQ: begin
        ctrl_m_axi_arvalid = 1'b1;
        if (ctrl_m_axi_arready) state_nx = RD_RESP;
      end
      RD_RESP: begin
        ctrl_m_axi_rready = 1'b1;
        if (ctrl_m_axi_rvalid) state_nx = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nx = rsp_timeout ? ERR : IDLE;
      end
      ERR: state_nx = ERR;
      default: state_nx = IDLE;
    endcase
    // watchdog abort overrides whatever the bus was doing
    if (abort) state_nx = RSP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q  <= {cmd_addr[31:2], 2'b00};
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WR_REQ) begin
        if (ctrl_m_axi_awready) aw_done <= 1'b1;
        if (ctrl_m_axi_wready)  w_done  <= 1'b1;
      end
      if (abort) begin
        rsp_rdata <= '0;
        rsp_resp  <= 2'b10;
      end else if ((state == WR_RESP) && ctrl_m_axi_bvalid) begin
        rsp_rdata <= '0;
        rsp_resp  <= ctrl_m_axi_bresp;
      end else if ((state == RD_RESP) && ctrl_m_axi_rvalid) begin
        rsp_rdata <= ctrl_m_axi_rdata;
        rsp_resp  <= ctrl_m_axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_udt_cfg_master.sv
// tb_udt_cfg_master: directed scoreboard bench for udt_cfg_master.
// Watchdog steps run only when UDT_CFG_TIMEOUT_EN is defined.
module tb_udt_cfg_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, bus_err;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 0, wvalid, wready = 0;
  logic [1:0]  bresp = 0;
  logic        bvalid = 0, bready;
  logic        arvalid, arready = 0;
  logic [31:0] rdata = 0;
  logic [1:0]  rresp = 0;
  logic        rvalid = 0, rready;

  always #5 clk = ~clk;

  udt_cfg_master #(.TIMEOUT_CYCLES(16)) dut (
    .ctrl_m_axi_aclk(clk), .ctrl_m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .bus_err(bus_err),
    .ctrl_m_axi_awaddr(awaddr), .ctrl_m_axi_awvalid(awvalid),
    .ctrl_m_axi_awready(awready),
    .ctrl_m_axi_wdata(wdata), .ctrl_m_axi_wstrb(wstrb),
    .ctrl_m_axi_wvalid(wvalid), .ctrl_m_axi_wready(wready),
    .ctrl_m_axi_bresp(bresp), .ctrl_m_axi_bvalid(bvalid),
    .ctrl_m_axi_bready(bready),
    .ctrl_m_axi_araddr(araddr), .ctrl_m_axi_arvalid(arvalid),
    .ctrl_m_axi_arready(arready),
    .ctrl_m_axi_rdata(rdata), .ctrl_m_axi_rresp(rresp),
    .ctrl_m_axi_rvalid(rvalid), .ctrl_m_axi_rready(rready)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // drive one command at a negedge; returns in cycle 1 after accept
  task automatic issue(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input rsp_t e);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_write = wr;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    sb.push_back(e);
    step();
    cyc = 1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int max, output int l);
    int   n;
    rsp_t e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    l = cyc;
    chk("rsp_seen", 32'(rsp_valid), 1);
    if (rsp_valid === 1'b1) begin
      chk("sb_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
      end
    end
  endtask

  task automatic ack();
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_dropped", 32'(rsp_valid), 0);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 0);
    chk("rst_err", {rsp_timeout, bus_err}, 0);
    step(); step();
    rst_n = 1;
    step();

    // write, always-ready slave, rsp_ready already high
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    rsp_ready = 1;
    issue(1, 32'h0000_000B, 32'h0000_2000, 4'hF, '{0, 2'b00, 1'b0});
    chk("w1_awvalid_c1", 32'(awvalid), 1);
    chk("w1_wvalid_c1", 32'(wvalid), 1);
    chk("w1_awaddr", awaddr, 32'h8);
    chk("w1_wdata", wdata, 32'h2000);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    step();
    chk("w1_valids_c2", {awvalid, wvalid}, 0);
    chk("w1_bready_c2", 32'(bready), 1);
    wait_rsp(6, lat);
    chk("w1_latency", lat, 3);
    step();
    rsp_ready = 0;
    chk("w1_rsp_1cyc", 32'(rsp_valid), 0);

    // staggered handshakes: W at cycle 1, AW at cycle 4, SLVERR passthrough
    awready = 0; wready = 1; bvalid = 0;
    issue(1, 32'h0000_0102, 32'h0000_A5A5, 4'h3, '{0, 2'b10, 1'b0});
    chk("w2_both_c1", {awvalid, wvalid}, 2'b11);
    step();
    wready = 0;
    chk("w2_wvalid_c2", 32'(wvalid), 0);
    chk("w2_awvalid_c2", 32'(awvalid), 1);
    chk("w2_awaddr_c2", awaddr, 32'h100);
    step();
    chk("w2_awvalid_c3", 32'(awvalid), 1);
    chk("w2_awaddr_c3", awaddr, 32'h100);
    step();
    awready = 1;
    chk("w2_awvalid_c4", 32'(awvalid), 1);
    chk("w2_no_bready_c4", 32'(bready), 0);
    step();
    awready = 0;
    chk("w2_awvalid_c5", 32'(awvalid), 0);
    chk("w2_bready_c5", 32'(bready), 1);
    bvalid = 1; bresp = 2'b10;
    step();
    bvalid = 0;
    chk("w2_bready_c6", 32'(bready), 0);
    wait_rsp(4, lat);
    chk("w2_latency", lat, 6);
    ack();

    // read with rvalid delayed 5 cycles
    arready = 1; rvalid = 0; rdata = 32'h0001_F400; rresp = 2'b00;
    issue(0, 32'h0000_0044, 32'h0, 4'h0, '{32'h0001_F400, 2'b00, 1'b0});
    chk("r1_arvalid", 32'(arvalid), 1);
    chk("r1_araddr", araddr, 32'h44);
    step();
    arready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("r1_rready_wait", 32'(rready), 1);
      chk("r1_no_rsp", 32'(rsp_valid), 0);
      step();
    end
    rvalid = 1;
    chk("r1_rready_c7", 32'(rready), 1);
    step();
    rvalid = 0;
    wait_rsp(4, lat);
    chk("r1_latency", lat, 8);
    ack();

    // back-pressure with a second read held on cmd_valid, DECERR passthrough
    arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
    issue(0, 32'h0000_0080, 32'h0, 4'h0, '{32'hDEAD_BEEF, 2'b11, 1'b0});
    cmd_valid = 1;
    wait_rsp(6, lat);
    chk("bp_latency", lat, 3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_resp", 32'(rsp_resp), 3);
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    sb.push_back('{32'hDEAD_BEEF, 2'b11, 1'b0});
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("bp_idle_after", 32'(cmd_ready), 1);
    step();
    cyc = 1;
    cmd_valid = 0;
    wait_rsp(6, lat);
    chk("bp2_latency", lat, 3);
    ack();
    rvalid = 0; rresp = 2'b00;

`ifdef UDT_CFG_TIMEOUT_EN
    // watchdog: awready never comes
    awready = 0; wready = 1; bvalid = 0;
    issue(1, 32'h0000_0200, 32'h1, 4'hF, '{0, 2'b10, 1'b1});
    while (cyc < 16) begin
      chk("to_awvalid_hold", 32'(awvalid), 1);
      step();
    end
    chk("to_awvalid_c16", 32'(awvalid), 1);
    step();
    chk("to_valids_c17", {awvalid, wvalid, bready, arvalid, rready}, 0);
    wait_rsp(2, lat);
    chk("to_latency", lat, 17);
    chk("to_bus_err", 32'(bus_err), 1);
    ack();
    cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("to_cmd_ready_err", 32'(cmd_ready), 0);
      step();
    end
    cmd_valid = 0;
    wready = 0;
`else
    chk("no_to_flag", 32'(rsp_timeout), 0);
    chk("no_bus_err", 32'(bus_err), 0);
`endif

    // reset pulsed while in WR_RESP
    awready = 1; wready = 1; bvalid = 0;
    issue(1, 32'h0000_0300, 32'h5, 4'hF, '{0, 2'b00, 1'b0});
    step();
    chk("rst_mid_bready", 32'(bready), 1);
    #2 rst_n = 0;
    #1;
    chk("rstm_cmd_ready", 32'(cmd_ready), 1);
    chk("rstm_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("rstm_awaddr", awaddr, 0);
    chk("rstm_wdata", wdata, 0);
    chk("rstm_rsp", {rsp_rdata[29:0], rsp_resp}, 0);
    chk("rstm_err", {rsp_timeout, bus_err}, 0);
    sb.delete();
    step(); step();
    rst_n = 1;
    awready = 0; wready = 0;
    step();
    arready = 1; rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
    issue(0, 32'h0000_0013, 32'h0, 4'h0, '{32'h1234_5678, 2'b00, 1'b0});
    chk("rr_araddr", araddr, 32'h10);
    wait_rsp(6, lat);
    chk("rr_latency", lat, 3);
    ack();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udt_cfg_master.md
# udt_cfg_master

AXI-Lite master that issues single-beat register writes and reads toward the UDT configuration register block (`ctrl_s_axi_*` slave). A simple command/response stream from the host-side controller or test sequencer drives it. It converts each command into one AXI-Lite transaction and returns write status or read data. It handles independent AW/W handshakes, response back-pressure, and an optional bus-hang watchdog.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: watchdog limit in clock cycles, measured from command acceptance. Legal range 2..65535.

Ports:
- `ctrl_m_axi_aclk` in 1: the single clock.
- `ctrl_m_axi_aresetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address. Bits [1:0] are ignored and forced to 0 on the bus.
- `cmd_wdata` in 32, `cmd_wstrb` in 4: write data and byte enables.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data. Always 0 for writes.
- `rsp_resp` out 2: captured BRESP/RRESP, or 2'b10 on timeout.
- `rsp_timeout` out 1: response was produced by the watchdog.
- `bus_err` out 1: sticky flag, set by a timeout.
- `ctrl_m_axi_awaddr` out 32, `ctrl_m_axi_awvalid` out 1, `ctrl_m_axi_awready` in 1.
- `ctrl_m_axi_wdata` out 32, `ctrl_m_axi_wstrb` out 4, `ctrl_m_axi_wvalid` out 1, `ctrl_m_axi_wready` in 1.
- `ctrl_m_axi_bresp` in 2, `ctrl_m_axi_bvalid` in 1, `ctrl_m_axi_bready` out 1.
- `ctrl_m_axi_araddr` out 32, `ctrl_m_axi_arvalid` out 1, `ctrl_m_axi_arready` in 1.
- `ctrl_m_axi_rdata` in 32, `ctrl_m_axi_rresp` in 2, `ctrl_m_axi_rvalid` in 1, `ctrl_m_axi_rready` out 1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, ERR.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, register the address (bits [1:0] = 0), data and strobe.
  - Go to WR_REQ if `cmd_write` = 1, otherwise RD_REQ.
- WR_REQ:
  - `awvalid` and `wvalid` both rise on entry.
  - Each drops independently on its own handshake. The AW and W handshakes may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - `bready` = 1.
  - On `bvalid`, capture `bresp` into `rsp_resp`, set `rsp_rdata` = 0, go to RSP.
- RD_REQ:
  - `arvalid` = 1 until `arready`, then go to RD_RESP.
- RD_RESP:
  - `rready` = 1.
  - On `rvalid`, capture `rdata` and `rresp`, go to RSP.
- RSP:
  - `rsp_valid` = 1.
  - `rsp_rdata`, `rsp_resp` and `rsp_timeout` are held stable until `rsp_ready`, then return to IDLE.
- Only one transaction is outstanding at a time. `cmd_ready` is 0 in every state except IDLE.
- AXI address/data outputs are held stable while their valid is high. Valids never drop before their handshake, except on watchdog abort.
- Slave responses SLVERR/DECERR are passed through unchanged. They are not treated as errors by this block.

## Timing
- Reset state:
  - FSM in IDLE.
  - All valid/ready outputs 0 except `cmd_ready` = 1.
  - `rsp_rdata` = 0, `rsp_resp` = 0, `rsp_timeout` = 0, `bus_err` = 0.
  - Address/data outputs = 0.
- Cycle numbering: cycle 0 is the accept edge.
  - Valids are high from cycle 1.
  - With an always-ready slave: write handshakes in cycle 1, `bready` high in cycle 2. If `bvalid` is also in cycle 2, `rsp_valid` rises in cycle 3.
  - Minimum command-to-response latency is 3 cycles for writes and 3 cycles for reads.
- `rsp_ready` may already be high when `rsp_valid` rises. In that case the response lasts exactly 1 cycle and the next command can be accepted on the following cycle.
- Reset asserted mid-transaction: immediate return to the reset state. The outstanding bus beat is abandoned, and the slave is reset in the same domain.

## Configuration
- Macro: `UDT_CFG_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches `TIMEOUT_CYCLES`-1 without completing, all AXI valid/ready outputs drop in the next cycle.
  - The response is then issued in RSP with `rsp_resp` = 2'b10, `rsp_timeout` = 1, `rsp_rdata` = 0, and `bus_err` set.
  - After the response handshake the FSM enters ERR, where `cmd_ready` = 0 permanently until reset.
- Not defined:
  - No counter is present.
  - The block waits indefinitely.
  - `rsp_timeout` and `bus_err` are tied to 0, and the ERR state is unreachable.

## Test plan
- Write, slave always ready: write addr 0x0000_000B, data 0x0000_2000, strb 0xF. Required: `awaddr` = 0x0000_0008, `awvalid`/`wvalid` high for exactly 1 cycle, `rsp_valid` in cycle 3 with `rsp_resp` = 0.
- Staggered write handshakes: `wready` at cycle 1, `awready` at cycle 4. Required: `wvalid` drops after cycle 1, `awvalid` held with a stable address until cycle 4, and exactly one `bready` phase follows.
- Read with `rvalid` delayed 5 cycles carrying 0x0001_F400, `rresp` = 0. Required: `rsp_rdata` = 0x0001_F400, `rsp_resp` = 0, `rready` high throughout the wait.
- Response back-pressure: `rsp_ready` low for 10 cycles with `cmd_valid` held high. Required: response fields stable, `cmd_ready` = 0 until the response handshake.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 16): `awready` never asserted. Required: `awvalid` drops after cycle 16, `rsp_resp` = 2'b10, `rsp_timeout` = 1, `bus_err` = 1, `cmd_ready` stays 0 afterwards.
- Reset pulsed in WR_RESP. Required: all outputs return to reset values asynchronously, and a new read is accepted correctly after release.
